// File: rtl/tx_byte_sequencer_if.sv
// Handshake and status bundle between a byte producer/consumer and tx_byte_sequencer.
// master drives bytes in and accepts bytes out; slave is the sequencer itself.
interface tx_byte_sequencer_if #(
    parameter int LVL_W = 7
);
    logic [7:0]       data_tx;
    logic             wren_fifo_tx;
    logic [7:0]       size_fifo_tx;
    logic             start_tx;
    logic             ready_tx;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             tx_done;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    modport master (
        output data_tx, wren_fifo_tx, size_fifo_tx, start_tx, out_ready,
        input  ready_tx, out_data, out_valid, tx_done, fifo_level, overflow
    );

    modport slave (
        input  data_tx, wren_fifo_tx, size_fifo_tx, start_tx, out_ready,
        output ready_tx, out_data, out_valid, tx_done, fifo_level, overflow
    );
endinterface

// File: rtl/tx_byte_sequencer.sv
// Byte FIFO plus frame sequencer: queues bytes, then on start_tx streams
// min(size, level) of them downstream over a valid/ready handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | ready_tx high, waiting for start_tx; nothing presented
//   SEND    | out_valid high, head of FIFO on out_data, counting bytes
//   DONE    | one-cycle tx_done pulse, then back to IDLE
module tx_byte_sequencer #(
    parameter int DEPTH = 64,
    parameter int LVL_W = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tx_byte_sequencer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic [7:0]       r_count;
    logic             r_overflow;
    logic             r_out_valid;
    logic             r_tx_done;
    logic             r_ready_tx;

    logic             w_full;
    logic             w_xfer;
    logic             w_wr_acc;
    logic             w_wr_drop;
    logic             w_start;
    logic [8:0]       w_size9;
    logic [8:0]       w_lvl9;
    logic [7:0]       w_frame_cnt;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_xfer    = r_out_valid & bus.out_ready;
    // A transfer in the same cycle frees a slot, so a write at full still lands.
    assign w_wr_acc  = bus.wren_fifo_tx & (~w_full | w_xfer);
    assign w_wr_drop = bus.wren_fifo_tx & ~w_wr_acc;
    assign w_start   = (r_state == ST_IDLE) & bus.start_tx;

    // Frame length is clamped to what is queued at the start cycle only.
    assign w_size9     = {1'b0, bus.size_fifo_tx};
    assign w_lvl9      = 9'(r_level);
    assign w_frame_cnt = (w_size9 <= w_lvl9) ? bus.size_fifo_tx : w_lvl9[7:0];

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= bus.data_tx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_xfer) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_wr_acc) - LVL_W'(w_xfer);
        end
    end

    // A drop in the start cycle itself is still reported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end else if (w_start) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_tx_done   <= 1'b0;
            r_ready_tx  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_done <= 1'b0;
                    if (bus.start_tx) begin
                        r_count    <= w_frame_cnt;
                        r_ready_tx <= 1'b0;
                        if (w_frame_cnt == 8'd0) begin
                            r_state   <= ST_DONE;
                            r_tx_done <= 1'b1;
                        end else begin
                            r_state     <= ST_SEND;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_count <= r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b0;
                            r_tx_done   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_tx_done  <= 1'b0;
                    r_ready_tx <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_tx_done   <= 1'b0;
                    r_ready_tx  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_data   = r_mem[r_rptr];
    assign bus.out_valid  = r_out_valid;
    assign bus.ready_tx   = r_ready_tx;
    assign bus.tx_done    = r_tx_done;
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_overflow;
endmodule

// File: doc/tx_byte_sequencer.md
TX_BYTE_SEQUENCER -- requirements
Module: tx_byte_sequencer

Interface
REQ-001 Parameter DEPTH, default 64, FIFO depth in bytes (power of two, 4..256).
REQ-002 Parameter LVL_W, default 7, width of fifo_level (log2(DEPTH)+1).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 data_tx  input  8  byte to enqueue.
REQ-006 wren_fifo_tx  input  1  enqueue strobe; one byte per high cycle.
REQ-007 size_fifo_tx  input  8  number of bytes to send, sampled with start_tx.
REQ-008 start_tx  input  1  single-cycle frame start request.
REQ-009 ready_tx  output  1  high when idle and able to accept start_tx.
REQ-010 out_data  output  8  byte presented downstream.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
REQ-013 tx_done  output  1  one-cycle pulse at frame end.
REQ-014 fifo_level  output  LVL_W  current byte count, 0..DEPTH.
REQ-015 overflow  output  1  sticky: a write was dropped because the FIFO was full.

Function
REQ-016 FIFO SHALL be circular, read/write pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 Write with level < DEPTH SHALL store data_tx at write pointer; level +1 next cycle.
REQ-018 Write with level == DEPTH SHALL be dropped, pointers and level unchanged, overflow = 1 next cycle.
REQ-019 Writes SHALL be accepted in every FSM state, including during frame transmission.
REQ-020 Simultaneous accepted write and transfer SHALL leave level unchanged; a write at full coinciding with a transfer SHALL be accepted.
REQ-021 FSM states: IDLE, SEND, DONE.
REQ-022 IDLE: ready_tx = 1, out_valid = 0.
REQ-023 IDLE + start_tx: frame count = min(size_fifo_tx, fifo_level), sampled the same cycle; overflow cleared.
REQ-024 If frame count = 0, next state DONE, otherwise SEND; ready_tx = 0 from the next cycle.
REQ-025 SEND: out_valid = 1, out_data = byte at read pointer (first-word fall-through); first byte valid the cycle after start_tx.
REQ-026 SEND: out_data and out_valid SHALL hold stable while out_ready = 0.
REQ-027 SEND transfer: read pointer +1, level -1, remaining count -1; on the last byte, next state DONE with out_valid = 0.
REQ-028 DONE: tx_done = 1 for exactly one cycle, ready_tx = 0; next state IDLE unconditionally.
REQ-029 start_tx outside IDLE SHALL be ignored, with no effect on count or overflow.
REQ-030 Bytes written after the start cycle SHALL NOT extend the current frame; they remain queued.
REQ-031 Back-to-back transfers SHALL sustain one byte per cycle with out_ready held high.
REQ-032 Minimum start-to-ready_tx latency: count N with out_ready constant 1 -> ready_tx high again N+2 cycles after start.

Reset
REQ-033 reset_n low SHALL immediately force: IDLE, pointers 0, level 0, overflow 0, tx_done 0, out_valid 0, ready_tx 1.
REQ-034 Reset mid-frame SHALL discard all queued and in-flight bytes; no tx_done pulse is generated.
REQ-035 FIFO storage contents need not be reset.

Verification
REQ-036 Write 0x11,0x22,0x33; start_tx with size 3; out_ready = 1 -> 0x11,0x22,0x33 on consecutive cycles, tx_done 1 cycle later, level 0, ready_tx high at start+5.
REQ-037 Write 2 bytes; start_tx with size 5 -> exactly 2 bytes sent, then tx_done.
REQ-038 Fill 64 bytes, write a 65th -> level 64, overflow 1; next start_tx clears overflow.
REQ-039 During a 4-byte frame, toggle out_ready 0/1 and write 0xAA at the same cycle as a transfer -> data held stable while stalled, level unchanged on the coincident cycle, 0xAA remains queued after tx_done.
REQ-040 Start a frame with size 0 or an empty FIFO -> no out_valid, tx_done 1 cycle after start.
REQ-041 Assert reset_n low mid-frame after 2 of 6 bytes -> outputs return to reset values immediately, no tx_done; subsequent pointer wrap past 63 -> bytes delivered in order.
